feature_packer: RTL and testbench
=================================

// Module: feature_packer
// PURPOSE
//  Upstream front-end of hdc_sensor_fusion. Accepts one raw sensor sample per handshake, in channel order.
//  Quantizes each sample to a 2-bit level against three thresholds.
//  Packs a full frame of `TOTAL_NUM_CHANNEL levels into features_top and presents it with fin_valid/fin_ready.
//  Two frame buffers (ping-pong) let the next frame fill while the fusion core holds the current one.
// PARAMETERS
//  SAMPLE_WIDTH  16  width of signed raw sample and thresholds
//  Shared constants come from const.vh: `TOTAL_NUM_CHANNEL, `CHANNEL_WIDTH (=2), `ceilLog2.
// PORTS
//  clk           in   1                                        clock
//  rst           in   1                                        reset; asynchronous, active-high
//  s_valid       in   1                                        raw sample valid
//  s_ready       out  1                                        raw sample ready
//  s_sample      in   SAMPLE_WIDTH                             signed raw sample
//  s_sof         in   1                                        start-of-frame marker (channel 0)
//  th0,th1,th2   in   SAMPLE_WIDTH each                        signed quantization thresholds, quasi-static
//  fin_valid     out  1                                        frame valid to hdc_sensor_fusion
//  fin_ready     in   1                                        frame ready from hdc_sensor_fusion
//  features_top  out  `TOTAL_NUM_CHANNEL*`CHANNEL_WIDTH         packed frame
//  frame_err     out  1                                        one-cycle pulse on frame misalignment
// BEHAVIOUR
//  Handshakes
//  - Transfer occurs when valid&&ready, on both interfaces.
//  - fin_valid, once high, holds with a stable features_top until fin_ready.
//  Quantization (signed compares)
//  - level = (s>=th0)+(s>=th1)+(s>=th2), range 0..3.
//  - Defined for any threshold ordering; no saturation needed.
//  Packing
//  - Channel k (k-th sample of frame, k=0 first) goes to
//    features_top[(`TOTAL_NUM_CHANNEL-k)*2-1 -: 2]; channel 0 lands in the MSBs.
//  State
//  - Per-buffer status EMPTY/FILLING/FULL; wr_sel, rd_sel (1 bit each).
//  - ch_cnt: `ceilLog2(`TOTAL_NUM_CHANNEL) bits.
//  - s_ready = (buf[wr_sel] != FULL).
//  - fin_valid = (buf[rd_sel] == FULL).
//  - features_top = buf_data[rd_sel].
//  Fill
//  - Each accepted sample writes level at ch_cnt and sets the buffer to FILLING.
//  - At ch_cnt==`TOTAL_NUM_CHANNEL-1: buffer -> FULL, ch_cnt -> 0, wr_sel toggles.
//  Drain
//  - On fin handshake: buf[rd_sel] -> EMPTY, rd_sel toggles.
//  Latency: the last sample accepted in cycle N gives fin_valid=1 in cycle N+1 (buffers previously empty).
//  Both buffers FULL: s_ready=0. A fin handshake in cycle N frees one buffer; s_ready=1 in cycle N+1.
//  Simultaneous final-sample accept and fin handshake on the other buffer are both honoured in the same cycle.
//  Reset (asynchronous, including mid-frame)
//  - Partial and full frames are discarded.
//  - Both buffers EMPTY, ch_cnt=0, wr_sel=rd_sel=0.
//  - Outputs: s_ready=1, fin_valid=0, frame_err=0, features_top=0.
// CONFIGURATION
//  FEATURE_PACKER_FRAME_CHECK_EN defined
//  - s_sof with ch_cnt!=0: frame_err pulses. The partial frame is dropped and the sample is stored as channel 0.
//  - No s_sof with ch_cnt==0: frame_err pulses and the sample is discarded (accepted, not stored).
//  FEATURE_PACKER_FRAME_CHECK_EN undefined
//  - s_sof is ignored and ch_cnt simply wraps.
//  - frame_err is tied to 0.
// STRUCTURE
//  Package feature_packer_pkg
//  - typedef logic [1:0] level_t
//  - typedef logic signed [SAMPLE_WIDTH-1:0] sample_t
//  - enum {EMPTY, FILLING, FULL} buf_state_e
//  - localparam FRAME_BITS = `TOTAL_NUM_CHANNEL*`CHANNEL_WIDTH
//  Sub-module sample_quantizer: combinational sample + 3 thresholds -> level_t.
// TESTING
//  1. th=(-100,0,100); samples -101,-5,0,100 as ch0..3 -> levels 0,1,2,3 at features_top MSBs (8'b00_01_10_11).
//  2. Stream one full frame of level-2 samples, fin_ready=1 -> fin_valid one cycle after last accept;
//     features_top = all 2'b10; buffer frees the next cycle.
//  3. fin_ready=0; stream 2 frames -> s_ready=0 after the second frame's last sample;
//     assert fin_ready 1 cycle -> s_ready=1 the next cycle; frame 1 data seen before frame 2.
//  4. Assert rst asynchronously mid-frame (ch_cnt=7) -> fin_valid=0, s_ready=1 immediately;
//     the next frame packs from channel 0.
//  5. (FRAME_CHECK_EN) s_sof at ch_cnt=5 -> frame_err one cycle; the frame completes
//     `TOTAL_NUM_CHANNEL samples after that sof.
//  6. (FRAME_CHECK_EN) first sample without s_sof -> frame_err pulse; ch_cnt stays 0; nothing stored.

Source files
------------

// File: rtl/feature_packer_pkg.sv
// Shared types and sizing for the feature_packer front-end.
// Channel count and width fall back to local defaults when const.vh is not included.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 8
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 2
`endif
`ifndef ceilLog2
`define ceilLog2(x) ($clog2(x))
`endif

package feature_packer_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int NUM_CH       = `TOTAL_NUM_CHANNEL;
  localparam int CH_W         = `CHANNEL_WIDTH;
  localparam int FRAME_BITS   = `TOTAL_NUM_CHANNEL * `CHANNEL_WIDTH;
  localparam int CH_CNT_W     = `ceilLog2(`TOTAL_NUM_CHANNEL);

  typedef logic [1:0] level_t;
  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_e;

  // Element NUM_CH-1 sits in the MSBs, so channel k is stored at element NUM_CH-1-k.
  typedef logic [NUM_CH-1:0][CH_W-1:0] frame_t;

endpackage

// File: rtl/feature_packer_quantizer.sv
// Combinational 2-bit quantizer: counts how many thresholds the sample reaches.
module sample_quantizer
  import feature_packer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic signed [SAMPLE_WIDTH-1:0] th0,
  input  logic signed [SAMPLE_WIDTH-1:0] th1,
  input  logic signed [SAMPLE_WIDTH-1:0] th2,
  output level_t                         level
);

  logic ge0;
  logic ge1;
  logic ge2;

  // Summing the compare bits works for any threshold ordering and never exceeds 3.
  assign ge0   = (sample >= th0);
  assign ge1   = (sample >= th1);
  assign ge2   = (sample >= th2);
  assign level = level_t'(ge0) + level_t'(ge1) + level_t'(ge2);

endmodule

// File: rtl/feature_packer.sv
// Quantizes raw samples and packs them into ping-pong frame buffers for hdc_sensor_fusion.
// Optional frame alignment checking is enabled by defining FEATURE_PACKER_FRAME_CHECK_EN.
module feature_packer
  import feature_packer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] s_sample,
  input  logic                           s_sof,
  input  logic signed [SAMPLE_WIDTH-1:0] th0,
  input  logic signed [SAMPLE_WIDTH-1:0] th1,
  input  logic signed [SAMPLE_WIDTH-1:0] th2,
  output logic                           fin_valid,
  input  logic                           fin_ready,
  output logic [FRAME_BITS-1:0]          features_top,
  output logic                           frame_err
);

  localparam logic [CH_CNT_W-1:0] LAST_CH = CH_CNT_W'(NUM_CH - 1);

  buf_state_e            buf_state [2];
  frame_t                buf_data  [2];
  logic                  wr_sel;
  logic                  rd_sel;
  logic [CH_CNT_W-1:0]   ch_cnt;

  level_t                level;
  logic                  accept;
  logic                  fin_hs;
  logic                  restart;
  logic                  drop;
  logic                  store;
  logic                  last;
  logic [CH_CNT_W-1:0]   idx;
  logic [CH_CNT_W-1:0]   slot;

  sample_quantizer #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_quantizer (
    .sample(s_sample),
    .th0   (th0),
    .th1   (th1),
    .th2   (th2),
    .level (level)
  );

  assign s_ready      = (buf_state[wr_sel] != FULL);
  assign fin_valid    = (buf_state[rd_sel] == FULL);
  assign features_top = buf_data[rd_sel];

  assign accept = s_valid && s_ready;
  assign fin_hs = fin_valid && fin_ready;

`ifdef FEATURE_PACKER_FRAME_CHECK_EN
  assign restart = s_sof && (ch_cnt != '0);
  assign drop    = !s_sof && (ch_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && (restart || drop);
    end
  end
`else
  logic unused_sof;

  assign unused_sof = s_sof;
  assign restart    = 1'b0;
  assign drop       = 1'b0;
  assign frame_err  = 1'b0;
`endif

  // A restarting sof sample becomes channel 0 of the current buffer; stale slots get overwritten.
  assign idx   = restart ? '0 : ch_cnt;
  assign store = accept && !drop;
  assign last  = (idx == LAST_CH);
  assign slot  = LAST_CH - idx;

  // Fill and drain never touch the same buffer: fill needs it not FULL, drain needs it FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        buf_state[b] <= EMPTY;
        buf_data[b]  <= '0;
      end
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      ch_cnt <= '0;
    end else begin
      if (fin_hs) begin
        buf_state[rd_sel] <= EMPTY;
        rd_sel            <= ~rd_sel;
      end
      if (store) begin
        buf_data[wr_sel][slot] <= level;
        if (last) begin
          buf_state[wr_sel] <= FULL;
          wr_sel            <= ~wr_sel;
          ch_cnt            <= '0;
        end else begin
          buf_state[wr_sel] <= FILLING;
          ch_cnt            <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_feature_packer.sv
// Directed self-checking bench for feature_packer (8 channels, 16-bit frame).
// Frame-check scenarios run only when FEATURE_PACKER_FRAME_CHECK_EN is defined.
module tb_feature_packer;
  import feature_packer_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [15:0]      s_sample;
  logic                    s_sof;
  logic signed [15:0]      th0;
  logic signed [15:0]      th1;
  logic signed [15:0]      th2;
  logic                    fin_valid;
  logic                    fin_ready;
  logic [FRAME_BITS-1:0]   features_top;
  logic                    frame_err;

  int errors;
  int checks;
  logic signed [15:0] frame_vec [8];

  feature_packer #(.SAMPLE_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_sample    (s_sample),
    .s_sof       (s_sof),
    .th0         (th0),
    .th1         (th1),
    .th2         (th2),
    .fin_valid   (fin_valid),
    .fin_ready   (fin_ready),
    .features_top(features_top),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; presents one sample for exactly one rising edge.
  task automatic push(input logic signed [15:0] smp, input logic sof);
    s_valid  = 1'b1;
    s_sample = smp;
    s_sof    = sof;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) push(frame_vec[i], (i == 0));
  endtask

  task automatic fill_vec(input logic signed [15:0] v);
    for (int i = 0; i < 8; i++) frame_vec[i] = v;
  endtask

  task automatic drain_one();
    fin_ready = 1'b1;
    @(negedge clk);
    fin_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fin_valid got=%b exp=0", fin_valid); end
    checks++; if (features_top !== 16'h0000) begin errors++; $display("[TB] FAIL reset_features got=%h exp=0000", features_top); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1 || fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset got ready=%b valid=%b exp ready=1 valid=0", s_ready, fin_valid); end
  endtask

  task automatic test_quantize();
    frame_vec = '{-16'sd101, -16'sd5, 16'sd0, 16'sd100, -16'sd101, -16'sd5, 16'sd0, 16'sd100};
    push_frame(8);
    checks++; if (fin_valid !== 1'b1) begin errors++; $display("[TB] FAIL quant_valid got=%b exp=1", fin_valid); end
    checks++; if (features_top !== 16'h1B1B) begin errors++; $display("[TB] FAIL quant_levels got=%h exp=1b1b", features_top); end
    drain_one();
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL quant_drain got=%b exp=0", fin_valid); end
    checks++; if (features_top !== 16'h0000) begin errors++; $display("[TB] FAIL quant_next_buf got=%h exp=0000", features_top); end
  endtask

  task automatic test_unordered_thresholds();
    th0 = 16'sd100; th1 = 16'sd0; th2 = -16'sd100;
    frame_vec = '{16'sd200, 16'sd0, -16'sd100, -16'sd200, 16'sd100, -16'sd50, 16'sd50, -16'sd101};
    push_frame(8);
    checks++; if (features_top !== 16'hE4D8) begin errors++; $display("[TB] FAIL unordered_levels got=%h exp=e4d8", features_top); end
    drain_one();
    th0 = -16'sd100; th1 = 16'sd0; th2 = 16'sd100;
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL unordered_drain got=%b exp=0", fin_valid); end
  endtask

  task automatic test_stream();
    fill_vec(16'sd50);
    fin_ready = 1'b1;
    push_frame(8);
    checks++; if (fin_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_latency got=%b exp=1", fin_valid); end
    checks++; if (features_top !== 16'hAAAA) begin errors++; $display("[TB] FAIL stream_data got=%h exp=aaaa", features_top); end
    @(negedge clk);
    fin_ready = 1'b0;
    checks++; if (fin_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_free got valid=%b ready=%b exp valid=0 ready=1", fin_valid, s_ready); end
  endtask

  task automatic test_back_to_back();
    fill_vec(16'sd100);
    push_frame(8);
    fill_vec(-16'sd5);
    push_frame(8);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready got=%b exp=0", s_ready); end
    checks++; if (features_top !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_first_frame got=%h exp=ffff", features_top); end
    @(negedge clk);
    checks++; if (s_ready !== 1'b0 || features_top !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_hold got ready=%b data=%h exp ready=0 data=ffff", s_ready, features_top); end
    drain_one();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_freed got=%b exp=1", s_ready); end
    checks++; if (fin_valid !== 1'b1 || features_top !== 16'h5555) begin errors++; $display("[TB] FAIL b2b_second_frame got valid=%b data=%h exp valid=1 data=5555", fin_valid, features_top); end
    // final sample of the next frame lands in the same cycle the pending frame drains
    frame_vec = '{-16'sd101, -16'sd5, 16'sd0, 16'sd100, -16'sd101, -16'sd5, 16'sd0, 16'sd100};
    push_frame(7);
    fin_ready = 1'b1;
    push(frame_vec[7], 1'b0);
    fin_ready = 1'b0;
    checks++; if (fin_valid !== 1'b1 || features_top !== 16'h1B1B) begin errors++; $display("[TB] FAIL simul_data got valid=%b data=%h exp valid=1 data=1b1b", fin_valid, features_top); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL simul_ready got=%b exp=1", s_ready); end
    drain_one();
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_drain got=%b exp=0", fin_valid); end
  endtask

  task automatic test_async_reset();
    fill_vec(16'sd0);
    push_frame(8);
    push_frame(7);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fin_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_flags got valid=%b ready=%b exp valid=0 ready=1", fin_valid, s_ready); end
    checks++; if (features_top !== 16'h0000) begin errors++; $display("[TB] FAIL areset_features got=%h exp=0000", features_top); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame_vec = '{16'sd100, 16'sd100, -16'sd101, -16'sd101, 16'sd0, 16'sd0, -16'sd5, -16'sd5};
    push_frame(7);
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_partial got=%b exp=0", fin_valid); end
    push(frame_vec[7], 1'b0);
    checks++; if (fin_valid !== 1'b1 || features_top !== 16'hF0A5) begin errors++; $display("[TB] FAIL areset_refill got valid=%b data=%h exp valid=1 data=f0a5", fin_valid, features_top); end
    drain_one();
  endtask

`ifdef FEATURE_PACKER_FRAME_CHECK_EN
  task automatic test_sof_restart();
    fill_vec(-16'sd5);
    push_frame(5);
    push(16'sd100, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL restart_err got=%b exp=1", frame_err); end
    push(-16'sd101, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL restart_err_pulse got=%b exp=0", frame_err); end
    for (int i = 0; i < 5; i++) push(-16'sd101, 1'b0);
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_early got=%b exp=0", fin_valid); end
    push(-16'sd101, 1'b0);
    checks++; if (fin_valid !== 1'b1 || features_top !== 16'hC000) begin errors++; $display("[TB] FAIL restart_frame got valid=%b data=%h exp valid=1 data=c000", fin_valid, features_top); end
    drain_one();
  endtask

  task automatic test_missing_sof();
    push(16'sd100, 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL nosof_err got=%b exp=1", frame_err); end
    push(-16'sd5, 1'b1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL nosof_err_pulse got=%b exp=0", frame_err); end
    for (int i = 0; i < 6; i++) push(-16'sd5, 1'b0);
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL nosof_stored got=%b exp=0", fin_valid); end
    push(-16'sd5, 1'b0);
    checks++; if (fin_valid !== 1'b1 || features_top !== 16'h5555) begin errors++; $display("[TB] FAIL nosof_frame got valid=%b data=%h exp valid=1 data=5555", fin_valid, features_top); end
    drain_one();
  endtask
`else
  task automatic test_sof_ignored();
    for (int i = 0; i < 7; i++) begin
      push(-16'sd5, (i == 3));
      if (i == 3 || i == 0) begin
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL ignore_err got=%b exp=0", frame_err); end
      end
    end
    checks++; if (fin_valid !== 1'b0) begin errors++; $display("[TB] FAIL ignore_early got=%b exp=0", fin_valid); end
    push(16'sd100, 1'b0);
    checks++; if (fin_valid !== 1'b1 || features_top !== 16'h5557) begin errors++; $display("[TB] FAIL ignore_frame got valid=%b data=%h exp valid=1 data=5557", fin_valid, features_top); end
    drain_one();
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    s_valid   = 1'b0;
    s_sample  = '0;
    s_sof     = 1'b0;
    fin_ready = 1'b0;
    th0       = -16'sd100;
    th1       = 16'sd0;
    th2       = 16'sd100;
    test_reset();
    test_quantize();
    test_unordered_thresholds();
    test_stream();
    test_back_to_back();
    test_async_reset();
`ifdef FEATURE_PACKER_FRAME_CHECK_EN
    test_sof_restart();
    test_missing_sof();
`else
    test_sof_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
